// File: rtl/layer_ram_if.sv
// Interface between the network controller, weight/activation RAMs and the layer sequencer.
// The master modport is the controller/RAM side; the slave modport is the sequencer.
interface layer_ram_if #(
    parameter int DATA_W = 8,
    parameter int W_AW   = 6,
    parameter int A_AW   = 3
);
    logic              start;
    logic [1:0]        layer;
    logic              layer_sel;
    logic              w_rd_en;
    logic [W_AW-1:0]   w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              a_rd_en;
    logic [A_AW-1:0]   a_rd_addr;
    logic [DATA_W-1:0] a_rd_data;
    logic              a_wr_en;
    logic [A_AW-1:0]   a_wr_addr;
    logic [DATA_W-1:0] a_wr_data;
    logic              busy;
    logic              done;

    modport master (
        output start, layer, layer_sel, w_rd_data, a_rd_data,
        input  w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
               a_wr_en, a_wr_addr, a_wr_data, busy, done
    );

    modport slave (
        input  start, layer, layer_sel, w_rd_data, a_rd_data,
        output w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
               a_wr_en, a_wr_addr, a_wr_data, busy, done
    );
endinterface

// File: rtl/layer_ram_controller.sv
// Fully connected layer sequencer: streams weights/activations, accumulates per neuron,
// writes the scaled, saturated (optionally ReLU'd) result into the opposite activation bank.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | issuing N_IN weight/activation reads for neuron n
// DRAIN   | last read data arriving, final product accumulated
// WRITE   | result written to {~layer_sel, n}
// DONE    | one-cycle done pulse
module layer_ram_controller #(
    parameter int DATA_W = 8,
    parameter int FRAC   = 4,
    parameter int ACC_W  = 20,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int W_AW   = 6,
    parameter int A_AW   = 3,
    parameter int RELU   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    layer_ram_if.slave bus
);
    localparam int IW = A_AW - 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(2 ** (DATA_W - 1));

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                   r_state;
    logic [1:0]               r_layer;
    logic                     r_sel;
    logic [IW-1:0]            r_n;
    logic [IW-1:0]            r_i;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_vld;
    logic                     r_w_rd_en;
    logic [W_AW-1:0]          r_w_rd_addr;
    logic                     r_a_rd_en;
    logic [A_AW-1:0]          r_a_rd_addr;
    logic                     r_a_wr_en;
    logic [A_AW-1:0]          r_a_wr_addr;
    logic [DATA_W-1:0]        r_a_wr_data;
    logic                     r_busy;
    logic                     r_done;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    w_shift;
    logic [DATA_W-1:0]          w_res;

    assign w_prod     = $signed(bus.w_rd_data) * $signed(bus.a_rd_data);
    assign w_acc_next = r_vld ? (r_acc + ACC_W'(w_prod)) : r_acc;
    assign w_shift    = w_acc_next >>> FRAC;

    // Result is taken from the next-cycle accumulator so the DRAIN product is included.
    always_comb begin
        w_res = w_shift[DATA_W-1:0];
        if (w_shift > MAXV)
            w_res = MAXV[DATA_W-1:0];
        else if (w_shift < MINV)
            w_res = MINV[DATA_W-1:0];
        if ((RELU != 0) && w_res[DATA_W-1])
            w_res = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_layer     <= '0;
            r_sel       <= 1'b0;
            r_n         <= '0;
            r_i         <= '0;
            r_acc       <= '0;
            r_vld       <= 1'b0;
            r_w_rd_en   <= 1'b0;
            r_w_rd_addr <= '0;
            r_a_rd_en   <= 1'b0;
            r_a_rd_addr <= '0;
            r_a_wr_en   <= 1'b0;
            r_a_wr_addr <= '0;
            r_a_wr_data <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vld     <= r_w_rd_en;
            r_acc     <= w_acc_next;
            r_a_wr_en <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_layer     <= bus.layer;
                        r_sel       <= bus.layer_sel;
                        r_n         <= '0;
                        r_i         <= '0;
                        r_acc       <= '0;
                        r_w_rd_en   <= 1'b1;
                        r_a_rd_en   <= 1'b1;
                        r_w_rd_addr <= W_AW'(32'(bus.layer) * N_OUT * N_IN);
                        r_a_rd_addr <= {bus.layer_sel, IW'(0)};
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_i == IW'(N_IN - 1)) begin
                        r_w_rd_en <= 1'b0;
                        r_a_rd_en <= 1'b0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_i         <= r_i + IW'(1);
                        r_w_rd_addr <= r_w_rd_addr + W_AW'(1);
                        r_a_rd_addr <= {r_sel, r_i + IW'(1)};
                    end
                end
                S_DRAIN: begin
                    r_a_wr_en   <= 1'b1;
                    r_a_wr_addr <= {~r_sel, r_n};
                    r_a_wr_data <= w_res;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_n < IW'(N_OUT - 1)) begin
                        // Weights of consecutive neurons are contiguous, so the address just advances.
                        r_n         <= r_n + IW'(1);
                        r_i         <= '0;
                        r_acc       <= '0;
                        r_w_rd_en   <= 1'b1;
                        r_a_rd_en   <= 1'b1;
                        r_w_rd_addr <= r_w_rd_addr + W_AW'(1);
                        r_a_rd_addr <= {r_sel, IW'(0)};
                        r_state     <= S_RUN;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.w_rd_en   = r_w_rd_en;
    assign bus.w_rd_addr = r_w_rd_addr;
    assign bus.a_rd_en   = r_a_rd_en;
    assign bus.a_rd_addr = r_a_rd_addr;
    assign bus.a_wr_en   = r_a_wr_en;
    assign bus.a_wr_addr = r_a_wr_addr;
    assign bus.a_wr_data = r_a_wr_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_layer_ram_controller.sv
// Directed bench for layer_ram_controller: a ReLU and a linear instance run side by side
// against behavioural RAMs; writes, read addresses and done timing are logged and compared.
module tb_layer_ram_controller;
    localparam int DW = 8, WAW = 6, AAW = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    layer_ram_if #(.DATA_W(DW), .W_AW(WAW), .A_AW(AAW)) bus0 ();
    layer_ram_if #(.DATA_W(DW), .W_AW(WAW), .A_AW(AAW)) bus1 ();

    layer_ram_controller #(.DATA_W(DW), .FRAC(4), .ACC_W(20), .N_IN(4), .N_OUT(4),
                           .W_AW(WAW), .A_AW(AAW), .RELU(1))
        u_relu (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    layer_ram_controller #(.DATA_W(DW), .FRAC(4), .ACC_W(20), .N_IN(4), .N_OUT(4),
                           .W_AW(WAW), .A_AW(AAW), .RELU(0))
        u_lin (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    logic [7:0] wmem [0:63];
    logic [7:0] amem [0:7];

    logic       start;
    logic [1:0] layer;
    logic       layer_sel;
    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.layer = layer;  assign bus1.layer = layer;
    assign bus0.layer_sel = layer_sel;  assign bus1.layer_sel = layer_sel;

    always @(posedge clk) begin
        if (bus0.w_rd_en) bus0.w_rd_data <= wmem[bus0.w_rd_addr];
        if (bus0.a_rd_en) bus0.a_rd_data <= amem[bus0.a_rd_addr];
        if (bus1.w_rd_en) bus1.w_rd_data <= wmem[bus1.w_rd_addr];
        if (bus1.a_rd_en) bus1.a_rd_data <= amem[bus1.a_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write logs, one entry per write strobe
    int         wcnt0 = 0, wcnt1 = 0;
    logic [2:0] wa0 [0:63];
    logic [7:0] wd0 [0:63];
    logic [2:0] wa1 [0:63];
    logic [7:0] wd1 [0:63];
    always @(posedge clk) begin
        if (bus0.a_wr_en) begin
            wa0[6'(wcnt0)] <= bus0.a_wr_addr;
            wd0[6'(wcnt0)] <= bus0.a_wr_data;
            wcnt0 <= wcnt0 + 1;
        end
        if (bus1.a_wr_en) begin
            wa1[6'(wcnt1)] <= bus1.a_wr_addr;
            wd1[6'(wcnt1)] <= bus1.a_wr_data;
            wcnt1 <= wcnt1 + 1;
        end
    end

    // Read-address and done observers
    int         wn = 0, an = 0, dcnt = 0, dcnt1 = 0, dcyc = 0;
    logic       dbusy = 1'b0;
    logic [5:0] wal [0:255];
    logic [2:0] al  [0:255];
    always @(negedge clk) begin
        if (bus0.done) begin
            dcnt  = dcnt + 1;
            dcyc  = cyc;
            dbusy = bus0.busy;
        end
        if (bus1.done) dcnt1 = dcnt1 + 1;
        if (bus0.w_rd_en) begin
            wal[8'(wn)] = bus0.w_rd_addr;
            wn = wn + 1;
        end
        if (bus0.a_rd_en) begin
            al[8'(an)] = bus0.a_rd_addr;
            an = an + 1;
        end
    end

    int total = 0, bad = 0;
    int t0, bw, ba, bwc0, bwc1, bd, bd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " outs0"}, {bus0.w_rd_en, bus0.a_rd_en, bus0.a_wr_en, bus0.busy, bus0.done,
                              bus0.w_rd_addr, bus0.a_rd_addr, bus0.a_wr_addr, bus0.a_wr_data}, 32'd0);
        chk({tag, " outs1"}, {bus1.w_rd_en, bus1.a_rd_en, bus1.a_wr_en, bus1.busy, bus1.done,
                              bus1.w_rd_addr, bus1.a_rd_addr, bus1.a_wr_addr, bus1.a_wr_data}, 32'd0);
    endtask

    task automatic do_start(input logic [1:0] l, input logic s);
        @(posedge clk); #1;
        start = 1'b1; layer = l; layer_sel = s;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc; bw = wn; ba = an; bwc0 = wcnt0; bwc1 = wcnt1; bd = dcnt; bd1 = dcnt1;
        chk("busy_after_start", {31'd0, bus0.busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (dcnt == bd && k < 60) begin
            @(posedge clk); k++;
        end
        if (dcnt == bd) chk({tag, " done_timeout"}, 32'd0, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, " done_count"}, dcnt - bd, 32'd1);
        chk({tag, " done_count_lin"}, dcnt1 - bd1, 32'd1);
        chk({tag, " done_cycle"}, dcyc - t0, 32'd24);
        chk({tag, " busy_in_done"}, {31'd0, dbusy}, 32'd1);
        chk({tag, " busy_after"}, {31'd0, bus0.busy}, 32'd0);
    endtask

    task automatic chk_writes(input string tag, input logic [2:0] base,
                              input logic [31:0] e_relu, input logic [31:0] e_lin);
        chk({tag, " wr_count0"}, wcnt0 - bwc0, 32'd4);
        chk({tag, " wr_count1"}, wcnt1 - bwc1, 32'd4);
        for (int n = 0; n < 4; n++) begin
            chk({tag, " wr_addr"}, {29'd0, wa0[6'(bwc0 + n)]}, {29'd0, base + 3'(n)});
            chk({tag, " wr_relu"}, {24'd0, wd0[6'(bwc0 + n)]}, {24'd0, e_relu[8*n +: 8]});
            chk({tag, " wr_lin"},  {24'd0, wd1[6'(bwc1 + n)]}, {24'd0, e_lin[8*n +: 8]});
        end
    endtask

    task automatic fill(input logic [7:0] w, input logic [7:0] a);
        for (int j = 0; j < 64; j++) wmem[j] = w;
        for (int j = 0; j < 8; j++) amem[j] = a;
    endtask

    initial begin
        start = 1'b0; layer = 2'd0; layer_sel = 1'b0;
        fill(8'h00, 8'h00);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        // Unity-ish data: 4 * 16*16 = 1024 >>> 4 = 64
        fill(8'h10, 8'h10);
        do_start(2'd0, 1'b0);
        wait_done("basic");
        chk_writes("basic", 3'd4, 32'h40404040, 32'h40404040);
        chk("basic w_first", {26'd0, wal[8'(bw)]}, 32'd0);
        chk("basic w_reads", wn - bw, 32'd16);

        // Positive saturation
        fill(8'h7F, 8'h7F);
        do_start(2'd0, 1'b0);
        wait_done("satpos");
        chk_writes("satpos", 3'd4, 32'h7F7F7F7F, 32'h7F7F7F7F);

        // Negative result: ReLU clamps to 0, linear gives -64
        fill(8'hF0, 8'h10);
        do_start(2'd0, 1'b0);
        wait_done("neg");
        chk_writes("neg", 3'd4, 32'h00000000, 32'hC0C0C0C0);

        // Layer 2 from bank 1; weight 8*(n+1) per neuron -> 0x20,0x40,0x60,sat 0x7F
        fill(8'h00, 8'h00);
        for (int j = 0; j < 16; j++) wmem[32 + j] = 8'(8 * ((j / 4) + 1));
        for (int j = 4; j < 8; j++) amem[j] = 8'h10;
        do_start(2'd2, 1'b1);
        wait_done("layer2");
        chk_writes("layer2", 3'd0, 32'h7F604020, 32'h7F604020);
        chk("layer2 w_first", {26'd0, wal[8'(bw)]}, 32'd32);
        chk("layer2 w_last",  {26'd0, wal[8'(bw + 15)]}, 32'd47);
        chk("layer2 w_reads", wn - bw, 32'd16);
        for (int j = 0; j < 4; j++)
            chk("layer2 a_addr", {29'd0, al[8'(ba + j)]}, 32'(4 + j));

        // Start re-pulsed while busy with changed layer/bank
        fill(8'h10, 8'h10);
        do_start(2'd0, 1'b0);
        repeat (2) @(posedge clk); #1;
        start = 1'b1; layer = 2'd3; layer_sel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore");
        chk_writes("ignore", 3'd4, 32'h40404040, 32'h40404040);
        chk("ignore w_first", {26'd0, wal[8'(bw)]}, 32'd0);
        chk("ignore w_last",  {26'd0, wal[8'(bw + 15)]}, 32'd15);
        chk("ignore a_addr0", {29'd0, al[8'(ba)]}, 32'd0);

        // Reset at edge 10 mid-layer
        do_start(2'd0, 1'b0);
        repeat (9) @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_zero("midreset");
        repeat (40) @(posedge clk); #1;
        chk("midreset no_done", dcnt - bd, 32'd0);
        chk("midreset writes", wcnt0 - bwc0, 32'd1);
        chk("midreset busy", {31'd0, bus0.busy}, 32'd0);

        // Clean layer after reset: layer 1, bank 0
        do_start(2'd1, 1'b0);
        wait_done("fresh");
        chk_writes("fresh", 3'd4, 32'h40404040, 32'h40404040);
        chk("fresh w_first", {26'd0, wal[8'(bw)]}, 32'd16);
        chk("fresh w_last",  {26'd0, wal[8'(bw + 15)]}, 32'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
